// File: rtl/tcm_mem_initiator_pkg.sv
// Shared types for the TCM initiator: access sizes, FSM states and default window base.
package mem_defines;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } tcm_init_state_t;

   localparam logic [31:0] TCM_DEFAULT_BASE = 32'h0000_0000;

endpackage

// File: rtl/tcm_lane_align.sv
// Byte-lane alignment: store strobes/replicated data, and load extract/extend, from size and offset.
module tcm_lane_align
   import mem_defines::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  strb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   // Illegal size yields no strobes; the initiator never issues such an access anyway.
   always_comb begin
      strb_o  = 4'b0000;
      wdata_o = wdata_i;
      rdata_o = shifted;
      case (size_i)
         MEM_BYTE: begin
            strb_o  = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         end
         MEM_HALF: begin
            strb_o  = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         end
         MEM_WORD: begin
            strb_o  = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = shifted;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tcm_mem_initiator.sv
// Single-outstanding LSU-to-TCM initiator for one RAM port.
// Optional performance counters are built when TCM_INIT_PERF_EN is defined.
module tcm_mem_initiator
   import mem_defines::*;
#(
   parameter int          ADDR_WIDTH = 16,
   parameter logic [31:0] TCM_BASE   = TCM_DEFAULT_BASE
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [31:0]           req_addr_i,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-3:0] tcm_addr_o,
   output logic [31:0]           tcm_data_o,
   output logic [3:0]            tcm_wr_o,
   input  logic [31:0]           tcm_rdata_i,
   output logic [31:0]           perf_ld_cnt_o,
   output logic [31:0]           perf_st_cnt_o,
   output logic [31:0]           perf_err_cnt_o,
   output tcm_init_state_t       dbg_state_o
);

   localparam logic [32:0] WIN_LO   = {1'b0, TCM_BASE};
   localparam logic [32:0] WIN_SIZE = 33'd1 << ADDR_WIDTH;

   tcm_init_state_t state_q, state_d;
   logic            we_q, uns_q, err_q;
   logic [1:0]      off_q, size_q;
   logic [3:0]      strb_q;
   logic [31:0]     rdata_q;
   logic            accept, misalign, out_win, req_err;
   logic [32:0]     win_off;
   logic [3:0]      st_strb;
   logic [31:0]     st_data, ld_data;
   logic [31:0]     st_unused_rdata, ld_unused_wdata;
   logic [3:0]      ld_unused_strb;

   // Handshake: a transfer occurs on the rising edge where valid && ready are both high.
   // req_ready_o is high only in IDLE and rsp_valid_o only in RESP, so they never overlap.
   assign accept = req_valid_i && (state_q == IDLE);

   always_comb begin
      misalign = 1'b0;
      case (req_size_i)
         MEM_HALF: misalign = req_addr_i[0];
         MEM_WORD: misalign = |req_addr_i[1:0];
         default:  misalign = 1'b0;
      endcase
   end

   // 33-bit offset: an address below the base wraps to >= 2**32, beyond any window size.
   assign win_off = {1'b0, req_addr_i} - WIN_LO;
   assign out_win = (win_off >= WIN_SIZE);
   assign req_err = (req_size_i == 2'b11) || misalign || out_win;

   tcm_lane_align u_store_align (
      .size_i     (req_size_i),
      .off_i      (req_addr_i[1:0]),
      .unsigned_i (1'b0),
      .wdata_i    (req_wdata_i),
      .rdata_i    (32'h0),
      .strb_o     (st_strb),
      .wdata_o    (st_data),
      .rdata_o    (st_unused_rdata)
   );

   tcm_lane_align u_load_align (
      .size_i     (size_q),
      .off_i      (off_q),
      .unsigned_i (uns_q),
      .wdata_i    (32'h0),
      .rdata_i    (tcm_rdata_i),
      .strb_o     (ld_unused_strb),
      .wdata_o    (ld_unused_wdata),
      .rdata_o    (ld_data)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      tcm_wr_o    = 4'b0000;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = req_err ? RESP : ISSUE;
         end
         ISSUE: begin
            if (we_q) tcm_wr_o = strb_q;
            state_d = we_q ? RESP : WAIT;
         end
         WAIT: state_d = RESP;
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tcm_addr_o <= '0;
         tcm_data_o <= '0;
         strb_q     <= '0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         err_q      <= 1'b0;
         off_q      <= '0;
         size_q     <= '0;
         rdata_q    <= '0;
      end else begin
         if (accept) begin
            err_q   <= req_err;
            we_q    <= req_we_i;
            rdata_q <= '0;
            if (!req_err) begin
               tcm_addr_o <= req_addr_i[ADDR_WIDTH-1:2];
               tcm_data_o <= st_data;
               strb_q     <= st_strb;
               off_q      <= req_addr_i[1:0];
               size_q     <= req_size_i;
               uns_q      <= req_unsigned_i;
            end
         end
         if (state_q == WAIT) rdata_q <= ld_data;
      end
   end

   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign dbg_state_o = state_q;

`ifdef TCM_INIT_PERF_EN
   logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ld_cnt_q  <= '0;
         st_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if ((state_q == RESP) && rsp_ready_i) begin
         if (err_q)     err_cnt_q <= err_cnt_q + 32'd1;
         else if (we_q) st_cnt_q  <= st_cnt_q + 32'd1;
         else           ld_cnt_q  <= ld_cnt_q + 32'd1;
      end
   end

   assign perf_ld_cnt_o  = ld_cnt_q;
   assign perf_st_cnt_o  = st_cnt_q;
   assign perf_err_cnt_o = err_cnt_q;
`else
   assign perf_ld_cnt_o  = '0;
   assign perf_st_cnt_o  = '0;
   assign perf_err_cnt_o = '0;
`endif

endmodule

// File: doc/tcm_mem_initiator.md
Name: tcm_mem_initiator

Overview:
- Initiator for one port of the dual-port TCM RAM: (clk, addr, data, byte-write strobe in; read-first data out one cycle later).
- Accepts single load/store requests from the core LSU via valid/ready.
- Generates word address, byte-lane strobes and lane-shifted write data.
- Returns aligned, sign/zero-extended load data or store completion, one transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 16, byte-address width of the TCM; word index is ADDR_WIDTH-2 bits.
- TCM_BASE, 32'h0000_0000, byte base address of the TCM window; must be aligned to 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  single clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  mem_size_t: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extend when 1
- req_wdata_i  in  32  store data, LSB-justified
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned, out-of-window or illegal size
- tcm_addr_o  out  ADDR_WIDTH-2  word index to RAM
- tcm_data_o  out  32  lane-shifted write data
- tcm_wr_o  out  4  byte write strobes
- tcm_rdata_i  in  32  RAM read data, valid the cycle after address is presented
- perf_ld_cnt_o, perf_st_cnt_o, perf_err_cnt_o  out  32 each  counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert externally):
  - State IDLE.
  - req_ready_o=1.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - tcm_addr_o=0, tcm_data_o=0, tcm_wr_o=0.
  - Counters 0.
- Reset mid-transaction abandons it: no response is issued, and tcm_wr_o drops to 0 immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready_o = (state==IDLE).
- IDLE, on accept:
  - Error check: error if size==11, or misaligned (half: addr[0]!=0; word: addr[1:0]!=0), or addr outside [TCM_BASE, TCM_BASE+2**ADDR_WIDTH).
  - Error -> RESP with rsp_err_o=1, rsp_rdata_o=0. No TCM write ever issued.
  - Otherwise register the following, then go to ISSUE:
    - tcm_addr_o = addr[ADDR_WIDTH-1:2].
    - Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
    - tcm_data_o = wdata replicated: byte x4, half x2, word as-is.
    - Remember lane offset, size and unsigned.
- ISSUE (one cycle, RAM samples at its end):
  - Store -> RESP, rsp_err_o=0, rsp_rdata_o=0.
  - Load -> WAIT.
  - tcm_wr_o is nonzero only in ISSUE, and only for stores.
- WAIT:
  - Capture tcm_rdata_i, shift right by 8*offset, mask to size, sign-extend unless unsigned, into rsp_rdata_o.
  - Go to RESP.
- RESP: rsp_valid_o=1; outputs held stable until rsp_ready_i; then IDLE.
- Next request is accepted only in IDLE; no same-cycle response/accept overlap.
- Latency, accept edge to rsp_valid_o high: store 2 cycles, load 3 cycles, error 1 cycle.
- tcm_addr_o holds its last value outside ISSUE. Read-first RAM: a load never observes its own-cycle write, since there is only one outstanding transaction.
- Address arithmetic: window check uses a 33-bit compare to avoid wrap at 0xFFFF_FFFF.

Optional Feature:
- Macro TCM_INIT_PERF_EN.
- Defined:
  - perf_ld_cnt_o increments on each successful load response handshake.
  - perf_st_cnt_o increments on each successful store response handshake.
  - perf_err_cnt_o increments on each error response handshake.
  - All counters wrap at 2**32 and are cleared by reset.
- Undefined: counter logic omitted; all three outputs tied to 0.

Decomposition:
- mem_defines package:
  - mem_size_t enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - tcm_init_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - TCM_DEFAULT_BASE constant.
- One combinational sub-module, tcm_lane_align:
  - Store side: strobe and data replication from size/offset.
  - Load side: extract and extend from size/offset/unsigned.
  - Instanced once for each direction.

Test Plan:
- Store word 0xDEADBEEF @0x0000_0100 (TCM_BASE=0) -> tcm_addr_o=0x40, tcm_wr_o=4'hF in ISSUE only; rsp_valid_o at accept+2, err=0; RAM word 0x40 = 0xDEADBEEF.
- Load byte signed @0x103 after above -> rsp at accept+3, rsp_rdata_o=0xFFFFFFDE; unsigned -> 0x000000DE.
- Store half 0x1234 @0x102 -> tcm_wr_o=4'hC, tcm_data_o=0x12341234; word load @0x100 -> 0x1234BEEF.
- Misaligned word load @0x101, size=11, and addr 0x0001_0000 (ADDR_WIDTH=16) -> rsp_err_o=1 at accept+1, rdata=0, tcm_wr_o stays 0.
- Hold rsp_ready_i=0 for 5 cycles on a load -> rsp_valid_o/rdata stable, req_ready_o=0 throughout; new request is accepted the cycle after the handshake.
- Assert rst_n_i low during WAIT -> all outputs reset values the same cycle, no response after release. With TCM_INIT_PERF_EN, 3 loads/2 stores/1 error -> counters 3/2/1.
